// File: rtl/ring_sequencer_ex.sv
// ---------------------------------------------------------------------------
// ring_sequencer_ex
//   Walking-one ring sequencer. A single hot bit steps around a SIZE-bit ring.
//   The start position, lap length, direction and circular/one-shot mode are
//   captured when iStart is seen. Busy, wrap and done status are reported.
//   The one-hot output is meant to drive per-lane enables, for example the
//   channel selects of one-hot muxes.
//
// Parameters
//   SIZE   ring width in bits (>= 2)
//   IDX_W  index width, equal to clog2(SIZE)
//
// Ports
//   Clock        in   single clock; all logic updates on the rising edge
//   Reset        in   synchronous reset, active low
//   iStart       in   capture the run controls and begin a run (any state)
//   iStartIndex  in   first hot position (< SIZE)
//   iLength      in   positions per lap; 0 or a value above SIZE means SIZE
//   iDirection   in   0: step toward the MSB, 1: step toward the LSB
//   iMode        in   0: circular, 1: one-shot
//   iAdvance     in   step request
//   oHot         out  one-hot position; all zero when idle
//   oIndex       out  binary position; 0 when idle
//   oStep        out  advances since the start of the lap
//   oBusy        out  a run is in progress
//   oWrap        out  1-cycle pulse when a circular lap completes
//   oDone        out  1-cycle pulse when a one-shot run finishes
//   Every output comes straight from a flop.
// ---------------------------------------------------------------------------
module ring_sequencer_ex #(
    parameter int SIZE  = 16,
    parameter int IDX_W = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iStart,
    input  logic [IDX_W-1:0] iStartIndex,
    input  logic [IDX_W:0]   iLength,
    input  logic             iDirection,
    input  logic             iMode,
    input  logic             iAdvance,
    output logic [SIZE-1:0]  oHot,
    output logic [IDX_W-1:0] oIndex,
    output logic [IDX_W:0]   oStep,
    output logic             oBusy,
    output logic             oWrap,
    output logic             oDone
);

    localparam int LEN_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] MAX_IDX  = IDX_W'(SIZE - 1);
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(SIZE);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e state_q, state_d;

    // Run controls. These are captured on iStart and held until the next iStart.
    logic [IDX_W-1:0] start_q, start_d;
    logic [LEN_W-1:0] len_q,   len_d;
    logic             dir_q,   dir_d;
    logic             mode_q,  mode_d;

    // Position state and registered outputs.
    logic [IDX_W-1:0] idx_q,  idx_d;
    logic [LEN_W-1:0] step_q, step_d;
    logic [SIZE-1:0]  hot_q,  hot_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;

    logic [LEN_W-1:0] len_norm;
    logic [IDX_W-1:0] idx_next;
    logic             last_step;
    logic             adv_run;

    // Out-of-range lengths fall back to a full lap of the ring.
    always_comb begin
        len_norm = iLength;
        if (iLength == '0 || iLength > FULL_LEN) begin
            len_norm = FULL_LEN;
        end
    end

    // The neighbour position modulo SIZE. The explicit end checks keep this
    // correct when SIZE is not a power of two.
    always_comb begin
        if (dir_q) begin
            idx_next = (idx_q == '0) ? MAX_IDX : idx_q - 1'b1;
        end else begin
            idx_next = (idx_q == MAX_IDX) ? '0 : idx_q + 1'b1;
        end
    end

    // len_q is never 0 (normalised at capture, SIZE after reset), so len_q-1
    // cannot underflow.
    assign last_step = (step_q == len_q - 1'b1);
    assign adv_run   = (state_q == ST_RUN) && iAdvance;

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state. iStart wins over iAdvance in either state.
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (iStart) begin
            state_d = ST_RUN;
        end else if (adv_run && last_step && mode_q) begin
            state_d = ST_IDLE;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: outputs and datapath next values
    // ---------------------------------------------------------------------
    always_comb begin
        start_d = start_q;
        len_d   = len_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        step_d  = step_q;
        wrap_d  = 1'b0;
        done_d  = 1'b0;

        if (iStart) begin
            // A restart of a live run raises no wrap or done pulse.
            start_d = iStartIndex;
            len_d   = len_norm;
            dir_d   = iDirection;
            mode_d  = iMode;
            idx_d   = iStartIndex;
            step_d  = '0;
        end else if (adv_run) begin
            if (!last_step) begin
                idx_d  = idx_next;
                step_d = step_q + 1'b1;
            end else if (mode_q) begin
                // One-shot: the run ends and the outputs return to idle values.
                idx_d  = '0;
                step_d = '0;
                done_d = 1'b1;
            end else begin
                // Circular: start the lap again. With a length of 1 this
                // pulses wrap on every advance while the position stays put.
                idx_d  = start_q;
                step_d = '0;
                wrap_d = 1'b1;
            end
        end

        // Build the one-hot vector from the next index, so that oHot always
        // matches oIndex on the same cycle.
        hot_d = '0;
        if (state_d == ST_RUN) begin
            hot_d = SIZE'(1) << idx_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            start_q <= '0;
            len_q   <= FULL_LEN;
            dir_q   <= 1'b0;
            mode_q  <= 1'b0;
            idx_q   <= '0;
            step_q  <= '0;
            hot_q   <= '0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            start_q <= start_d;
            len_q   <= len_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            step_q  <= step_d;
            hot_q   <= hot_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign oHot   = hot_q;
    assign oIndex = idx_q;
    assign oStep  = step_q;
    assign oBusy  = (state_q == ST_RUN);
    assign oWrap  = wrap_q;
    assign oDone  = done_q;

endmodule

// File: tb/tb_ring_sequencer_ex.sv
// ---------------------------------------------------------------------------
// tb_ring_sequencer_ex
//   Directed scenarios followed by a random phase. Each cycle, every output
//   is compared with a reference model. The model keeps only the start, the
//   length and the step count, and computes the position arithmetically as
//   start +/- step (mod SIZE).
// ---------------------------------------------------------------------------
module tb_ring_sequencer_ex;

    localparam int SIZE  = 16;
    localparam int IDX_W = 4;

    logic             Clock = 1'b0;
    logic             Reset = 1'b0;
    logic             iStart = 1'b0;
    logic [IDX_W-1:0] iStartIndex = '0;
    logic [IDX_W:0]   iLength = '0;
    logic             iDirection = 1'b0;
    logic             iMode = 1'b0;
    logic             iAdvance = 1'b0;
    logic [SIZE-1:0]  oHot;
    logic [IDX_W-1:0] oIndex;
    logic [IDX_W:0]   oStep;
    logic             oBusy, oWrap, oDone;

    ring_sequencer_ex #(.SIZE(SIZE), .IDX_W(IDX_W)) dut (
        .Clock(Clock), .Reset(Reset), .iStart(iStart), .iStartIndex(iStartIndex),
        .iLength(iLength), .iDirection(iDirection), .iMode(iMode), .iAdvance(iAdvance),
        .oHot(oHot), .oIndex(oIndex), .oStep(oStep), .oBusy(oBusy),
        .oWrap(oWrap), .oDone(oDone)
    );

    always #5 Clock = ~Clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit m_busy, m_dir, m_mode, m_wrap, m_done;
    int m_start, m_len, m_step;

    function automatic int exp_idx();
        int off;
        if (!m_busy) return 0;
        off = m_dir ? -m_step : m_step;
        return ((m_start + off) % SIZE + SIZE) % SIZE;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (!Reset) begin
            m_busy = 0; m_step = 0; m_wrap = 0; m_done = 0;
        end else if (iStart) begin
            m_busy  = 1;
            m_start = int'(iStartIndex);
            m_len   = (iLength == 0 || int'(iLength) > SIZE) ? SIZE : int'(iLength);
            m_dir   = iDirection;
            m_mode  = iMode;
            m_step  = 0; m_wrap = 0; m_done = 0;
        end else begin
            m_wrap = 0; m_done = 0;
            if (m_busy && iAdvance) begin
                if (m_step == m_len - 1) begin
                    m_step = 0;
                    if (m_mode) begin m_busy = 0; m_done = 1; end
                    else m_wrap = 1;
                end else begin
                    m_step++;
                end
            end
        end
    endtask

    // One clock: the model follows the same inputs, then all outputs are checked.
    task automatic tick(string tag);
        int ei;
        @(posedge Clock);
        model_edge();
        #1;
        ei = exp_idx();
        chk({tag, ".hot"},   32'(oHot),   m_busy ? (32'd1 << ei) : 32'd0);
        chk({tag, ".index"}, 32'(oIndex), 32'(ei));
        chk({tag, ".step"},  32'(oStep),  32'(m_step));
        chk({tag, ".busy"},  32'(oBusy),  32'(m_busy));
        chk({tag, ".wrap"},  32'(oWrap),  32'(m_wrap));
        chk({tag, ".done"},  32'(oDone),  32'(m_done));
    endtask

    task automatic cyc(string tag, bit rst_n, bit st, int si, int ln, bit dr, bit md, bit adv);
        @(negedge Clock);
        Reset = rst_n; iStart = st; iStartIndex = IDX_W'(si); iLength = 5'(ln);
        iDirection = dr; iMode = md; iAdvance = adv;
        tick(tag);
    endtask

    task automatic adv(string tag, bit a);
        cyc(tag, 1, 0, int'(iStartIndex), int'(iLength), iDirection, iMode, a);
    endtask

    int t2_idx[5] = '{14, 15, 0, 1, 14};
    int t3_idx[3] = '{1, 0, 15};

    initial begin
        // Reset state
        cyc("rst", 0, 0, 0, 0, 0, 0, 0);
        cyc("rst", 0, 1, 3, 2, 0, 0, 1);

        // 1: reset mid-run at index 7
        cyc("t1", 1, 1, 5, 16, 0, 0, 0);
        adv("t1", 1);
        adv("t1", 1);
        chk("t1.at7", 32'(oIndex), 32'd7);
        cyc("t1r", 0, 0, 5, 16, 0, 0, 1);
        cyc("t1r", 0, 1, 5, 16, 0, 0, 1);
        for (int i = 0; i < 3; i++) adv("t1post", 1);
        chk("t1.idle_hot", 32'(oHot), 32'd0);

        // 2: circular up, start 14, length 4
        cyc("t2", 1, 1, 14, 4, 0, 0, 0);
        chk("t2.idx0", 32'(oIndex), 32'(t2_idx[0]));
        for (int i = 1; i < 5; i++) begin
            adv("t2", 1);
            chk("t2.idx", 32'(oIndex), 32'(t2_idx[i]));
            chk("t2.wrap_only_last", 32'(oWrap), (i == 4) ? 32'd1 : 32'd0);
        end

        // 3: one-shot down, start 1, length 3
        cyc("t3", 1, 1, 1, 3, 1, 1, 0);
        chk("t3.idx0", 32'(oIndex), 32'(t3_idx[0]));
        for (int i = 1; i < 3; i++) begin
            adv("t3", 1);
            chk("t3.idx", 32'(oIndex), 32'(t3_idx[i]));
        end
        adv("t3end", 1);
        chk("t3.done", 32'(oDone), 32'd1);
        chk("t3.busy", 32'(oBusy), 32'd0);
        adv("t3after", 0);
        chk("t3.done_pulse", 32'(oDone), 32'd0);

        // 4: length 0 and length 20 both mean a full lap
        cyc("t4a", 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) adv("t4a", 1);
        chk("t4a.wrap16", 32'(oWrap), 32'd1);
        cyc("t4b", 1, 1, 0, 20, 0, 0, 0);
        for (int i = 0; i < 15; i++) adv("t4b", 1);
        chk("t4b.idx15", 32'(oIndex), 32'd15);
        adv("t4b", 1);
        chk("t4b.wrap16", 32'(oWrap), 32'd1);

        // 5: start and advance on the same cycle while at index 5
        cyc("t5", 1, 1, 3, 8, 0, 0, 0);
        adv("t5", 1);
        adv("t5", 1);
        chk("t5.at5", 32'(oIndex), 32'd5);
        cyc("t5s", 1, 1, 10, 6, 1, 0, 1);
        chk("t5.newidx", 32'(oIndex), 32'd10);
        chk("t5.step0", 32'(oStep), 32'd0);

        // 6: advance while idle; gaps in the middle of a run
        cyc("t6idle", 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) adv("t6idle", i[0]);
        cyc("t6", 1, 1, 9, 5, 1, 0, 0);
        for (int i = 0; i < 12; i++) adv("t6gap", (i % 3) == 0);

        // Length 1 in both modes
        cyc("len1c", 1, 1, 6, 1, 0, 0, 0);
        adv("len1c", 1);
        adv("len1c", 1);
        cyc("len1o", 1, 1, 6, 1, 0, 1, 0);
        adv("len1o", 1);

        // Random phase
        for (int i = 0; i < 600; i++) begin
            cyc("rnd", $urandom_range(0, 99) != 0, $urandom_range(0, 11) == 0,
                int'($urandom_range(0, SIZE - 1)), int'($urandom_range(0, 20)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 9) < 7);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
